// File: rtl/ncpu32k_sram_arb_pkg.sv
// Shared definitions for the two-master SRAM arbiter: owner IDs and
// the default address width.
package ncpu32k_sram_arb_pkg;

    localparam int NCPU_AW_DEF = 32;

    // 1-bit owner IDs recorded per outstanding transaction
    typedef logic owner_t;
    localparam owner_t NCPU_SRAM_ARB_M0 = 1'b0;   // load/store unit
    localparam owner_t NCPU_SRAM_ARB_M1 = 1'b1;   // instruction fetch

    // The master that is not `id`
    function automatic owner_t other_master(input owner_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/ncpu32k_sram_arb_owner_fifo.sv
// 1-bit-wide owner FIFO, depth DEPTH (1 or 2). Records which master
// issued each outstanding SRAM transaction, in issue order.
module ncpu32k_sram_arb_owner_fifo
    import ncpu32k_sram_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  owner_t din,
    input  logic   pop,
    output owner_t dout,
    output logic   full,
    output logic   empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rptr];

    // Pointers wrap at DEPTH-1; count tracks occupancy, unchanged on push+pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem  <= '0;
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            end
            if (do_pop)
                rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ncpu32k_sram_arb.sv
// Two-master arbiter sharing one cmd/data SRAM port between the LSU (m0)
// and instruction fetch (m1). Zero added latency; responses are routed
// back to the issuing master in issue order via the owner FIFO.
// Build option: NCPU_SRAM_ARB_RR_EN selects round-robin on contention;
// when undefined m0 always wins contention (fixed priority).
module ncpu32k_sram_arb
    import ncpu32k_sram_arb_pkg::*;
#(
    parameter int DW          = 32,
    parameter int AW          = NCPU_AW_DEF,
    parameter int OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
    // m0: load/store unit
    input  logic            m0_cmd_valid,
    output logic            m0_cmd_ready,
    input  logic [AW-1:0]   m0_cmd_addr,
    input  logic [DW/8-1:0] m0_cmd_we_msk,
    input  logic [DW-1:0]   m0_din,
    output logic            m0_valid,
    input  logic            m0_ready,
    output logic [DW-1:0]   m0_dout,
    // m1: instruction fetch
    input  logic            m1_cmd_valid,
    output logic            m1_cmd_ready,
    input  logic [AW-1:0]   m1_cmd_addr,
    input  logic [DW/8-1:0] m1_cmd_we_msk,
    input  logic [DW-1:0]   m1_din,
    output logic            m1_valid,
    input  logic            m1_ready,
    output logic [DW-1:0]   m1_dout,
    // slave (SRAM) side
    output logic            s_cmd_valid,
    input  logic            s_cmd_ready,
    output logic [AW-1:0]   s_cmd_addr,
    output logic [DW/8-1:0] s_cmd_we_msk,
    output logic [DW-1:0]   s_din,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [DW-1:0]   s_dout
);

    logic [1:0]    req;
    owner_t        grant;
    owner_t        lock_id;
    logic          lock_vld;
    logic          cmd_blk;
    logic          accept;
    logic [DW-1:0] grant_din;
    logic [DW-1:0] din_hold;
    logic          fifo_full;
    logic          fifo_empty;
    owner_t        head;
    logic          pop;
`ifdef NCPU_SRAM_ARB_RR_EN
    owner_t        rr_ptr;
`endif

    assign req = {m1_cmd_valid, m0_cmd_valid};

    // Grant select: a presented-but-unaccepted command keeps its grant;
    // otherwise the single requester wins, and contention goes to the
    // round-robin pointer or to m0.
    always_comb begin
        grant = NCPU_SRAM_ARB_M0;
        if (lock_vld && req[lock_id])
            grant = lock_id;
        else if (req == 2'b10)
            grant = NCPU_SRAM_ARB_M1;
        else if (req == 2'b11)
`ifdef NCPU_SRAM_ARB_RR_EN
            grant = rr_ptr;
`else
            grant = NCPU_SRAM_ARB_M0;
`endif
    end

    // Reset also blocks commands so nothing leaks out while rst is high
    assign cmd_blk      = fifo_full | rst;
    assign s_cmd_valid  = (|req) & ~cmd_blk;
    assign accept       = s_cmd_valid & s_cmd_ready;
    assign m0_cmd_ready = req[0] & (grant == NCPU_SRAM_ARB_M0) & s_cmd_ready & ~cmd_blk;
    assign m1_cmd_ready = req[1] & (grant == NCPU_SRAM_ARB_M1) & s_cmd_ready & ~cmd_blk;

    assign s_cmd_addr   = (grant == NCPU_SRAM_ARB_M1) ? m1_cmd_addr   : m0_cmd_addr;
    assign s_cmd_we_msk = (grant == NCPU_SRAM_ARB_M1) ? m1_cmd_we_msk : m0_cmd_we_msk;
    assign grant_din    = (grant == NCPU_SRAM_ARB_M1) ? m1_din        : m0_din;

    // The slave samples din again when the write completes, so outside the
    // accept cycle it sees the held copy of the last accepted write data.
    assign s_din = accept ? grant_din : din_hold;

    // Lock the grant while a command is presented but not yet accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_vld <= 1'b0;
            lock_id  <= NCPU_SRAM_ARB_M0;
        end else if (accept) begin
            lock_vld <= 1'b0;
        end else if (s_cmd_valid) begin
            lock_vld <= 1'b1;
            lock_id  <= grant;
        end
    end

`ifdef NCPU_SRAM_ARB_RR_EN
    // After an accept, the other master is preferred on the next contention
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= NCPU_SRAM_ARB_M0;
        else if (accept)
            rr_ptr <= other_master(grant);
    end
`endif

    // Capture write data at each write accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            din_hold <= '0;
        else if (accept && (|s_cmd_we_msk))
            din_hold <= grant_din;
    end

    ncpu32k_sram_arb_owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   (grant),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Response steering to the owner at the FIFO head
    assign m0_valid = s_valid & ~fifo_empty & (head == NCPU_SRAM_ARB_M0);
    assign m1_valid = s_valid & ~fifo_empty & (head == NCPU_SRAM_ARB_M1);
    assign s_ready  = ~fifo_empty & ((head == NCPU_SRAM_ARB_M1) ? m1_ready : m0_ready);
    assign pop      = s_valid & s_ready;
    assign m0_dout  = s_dout;
    assign m1_dout  = s_dout;

`ifndef SYNTHESIS
    // A response with no recorded owner means the slave and arbiter disagree
    unowned_rsp: assert property (@(posedge clk) disable iff (rst) !(s_valid && fifo_empty));
`endif

endmodule

// File: tb/tb_ncpu32k_sram_arb.sv
// Directed bench for ncpu32k_sram_arb with a behavioural SRAM slave of
// programmable latency. Expectations follow NCPU_SRAM_ARB_RR_EN.
module tb_ncpu32k_sram_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_cmd_valid, m0_cmd_ready, m0_valid, m0_ready;
    logic [31:0] m0_cmd_addr, m0_din, m0_dout;
    logic [3:0]  m0_cmd_we_msk;
    logic        m1_cmd_valid, m1_cmd_ready, m1_valid, m1_ready;
    logic [31:0] m1_cmd_addr, m1_din, m1_dout;
    logic [3:0]  m1_cmd_we_msk;
    logic        s_cmd_valid, s_cmd_ready, s_valid, s_ready;
    logic [31:0] s_cmd_addr, s_din, s_dout;
    logic [3:0]  s_cmd_we_msk;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ncpu32k_sram_arb #(.DW(32), .AW(32), .OUTSTANDING(2)) dut (
        .clk(clk), .rst(rst),
        .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_addr(m0_cmd_addr),
        .m0_cmd_we_msk(m0_cmd_we_msk), .m0_din(m0_din), .m0_valid(m0_valid),
        .m0_ready(m0_ready), .m0_dout(m0_dout),
        .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_addr(m1_cmd_addr),
        .m1_cmd_we_msk(m1_cmd_we_msk), .m1_din(m1_din), .m1_valid(m1_valid),
        .m1_ready(m1_ready), .m1_dout(m1_dout),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_addr(s_cmd_addr),
        .s_cmd_we_msk(s_cmd_we_msk), .s_din(s_din),
        .s_valid(s_valid), .s_ready(s_ready), .s_dout(s_dout)
    );

    // ---------------- SRAM slave model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [3:0]  msk;
        int          due;
    } sent_t;

    logic [31:0] mem [0:63];
    sent_t       sq[$];
    int          cyc;
    int          slv_delay = 1;
    sent_t       e;

    // Accepts commands, completes them in order after slv_delay cycles;
    // write data is taken from s_din at completion.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sq.delete();
            cyc = 0;
            s_valid <= 1'b0;
            s_dout  <= '0;
        end else begin
            if (s_valid && s_ready) begin
                e = sq.pop_front();
                for (int b = 0; b < 4; b++)
                    if (e.msk[b]) mem[e.addr[7:2]][b*8 +: 8] = s_din[b*8 +: 8];
            end
            if (s_cmd_valid && s_cmd_ready)
                sq.push_back('{addr: s_cmd_addr, msk: s_cmd_we_msk, due: cyc + slv_delay});
            cyc++;
            if (sq.size() > 0 && sq[0].due <= cyc) begin
                s_valid <= 1'b1;
                s_dout  <= mem[sq[0].addr[7:2]];
            end else begin
                s_valid <= 1'b0;
                s_dout  <= '0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic idle_inputs();
        m0_cmd_valid = 0; m0_cmd_addr = '0; m0_cmd_we_msk = '0; m0_din = '0; m0_ready = 1;
        m1_cmd_valid = 0; m1_cmd_addr = '0; m1_cmd_we_msk = '0; m1_din = '0; m1_ready = 1;
        s_cmd_ready = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        m0_cmd_valid = 1; m1_cmd_valid = 1; m0_din = 32'hA5A5A5A5;
        rst = 1;
        #2;
        n_chk++; if (s_cmd_valid !== 1'b0) $display("FAIL reset_s_cmd_valid got=%b exp=0", s_cmd_valid); else n_pass++;
        n_chk++; if (m0_cmd_ready !== 1'b0) $display("FAIL reset_m0_cmd_ready got=%b exp=0", m0_cmd_ready); else n_pass++;
        n_chk++; if (m1_cmd_ready !== 1'b0) $display("FAIL reset_m1_cmd_ready got=%b exp=0", m1_cmd_ready); else n_pass++;
        n_chk++; if ({m0_valid, m1_valid} !== 2'b00) $display("FAIL reset_valid got=%b exp=00", {m0_valid, m1_valid}); else n_pass++;
        n_chk++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready got=%b exp=0", s_ready); else n_pass++;
        n_chk++; if (s_din !== 32'h0) $display("FAIL reset_din_hold got=%h exp=00000000", s_din); else n_pass++;
        repeat (2) @(negedge clk);
        idle_inputs();
        rst = 0;
    endtask

    task automatic test_single_read();
        do_reset();
        slv_delay = 3;
        mem[6'h04] = 32'hDEADBEEF;
        @(negedge clk);
        m0_cmd_valid = 1; m0_cmd_addr = 32'h10; #1;
        n_chk++; if (m0_cmd_ready !== 1'b1) $display("FAIL rd_accept got=%b exp=1", m0_cmd_ready); else n_pass++;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            m0_cmd_valid = 0; #1;
            if (k < 3) begin
                n_chk++; if (m0_valid !== 1'b0) $display("FAIL rd_early_valid cyc=%0d got=%b exp=0", k, m0_valid); else n_pass++;
            end
        end
        n_chk++; if (m0_valid !== 1'b1) $display("FAIL rd_valid got=%b exp=1", m0_valid); else n_pass++;
        n_chk++; if (m0_dout !== 32'hDEADBEEF) $display("FAIL rd_dout got=%h exp=deadbeef", m0_dout); else n_pass++;
        n_chk++; if (m1_valid !== 1'b0) $display("FAIL rd_m1_valid got=%b exp=0", m1_valid); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_contention();
        logic [1:0] exp;
        do_reset();
        slv_delay = 1;
        @(negedge clk);
        m0_cmd_valid = 1; m0_cmd_addr = 32'h10;
        m1_cmd_valid = 1; m1_cmd_addr = 32'h30;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
`ifdef NCPU_SRAM_ARB_RR_EN
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp = 2'b01;
`endif
            n_chk++;
            if ({m1_cmd_ready, m0_cmd_ready} !== exp)
                $display("FAIL contention_grant%0d got=%b exp=%b", i, {m1_cmd_ready, m0_cmd_ready}, exp);
            else n_pass++;
        end
        @(negedge clk);
        m0_cmd_valid = 0; m1_cmd_valid = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_grant_lock();
        do_reset();
        slv_delay = 1;
        s_cmd_ready = 0;
        @(negedge clk);
        m1_cmd_valid = 1; m1_cmd_addr = 32'h40; #1;
        n_chk++; if (s_cmd_addr !== 32'h40) $display("FAIL lock_first_addr got=%h exp=00000040", s_cmd_addr); else n_pass++;
        @(negedge clk);
        m0_cmd_valid = 1; m0_cmd_addr = 32'h50; #1;
        n_chk++; if (s_cmd_addr !== 32'h40) $display("FAIL lock_addr_held got=%h exp=00000040", s_cmd_addr); else n_pass++;
        n_chk++; if (m0_cmd_ready !== 1'b0) $display("FAIL lock_m0_ready got=%b exp=0", m0_cmd_ready); else n_pass++;
        @(negedge clk);
        s_cmd_ready = 1; #1;
        n_chk++; if ({m1_cmd_ready, m0_cmd_ready} !== 2'b10) $display("FAIL lock_accept got=%b exp=10", {m1_cmd_ready, m0_cmd_ready}); else n_pass++;
        n_chk++; if (s_cmd_addr !== 32'h40) $display("FAIL lock_accept_addr got=%h exp=00000040", s_cmd_addr); else n_pass++;
        @(negedge clk);
        m1_cmd_valid = 0; #1;
        n_chk++; if (m0_cmd_ready !== 1'b1 || s_cmd_addr !== 32'h50) $display("FAIL lock_next got=%b/%h exp=1/00000050", m0_cmd_ready, s_cmd_addr); else n_pass++;
        @(negedge clk);
        m0_cmd_valid = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write_read(input int dly);
        do_reset();
        slv_delay = dly;
        mem[6'h08] = 32'h0;
        @(negedge clk);
        m0_cmd_valid = 1; m0_cmd_addr = 32'h20; m0_cmd_we_msk = 4'b0101; m0_din = 32'h11223344; #1;
        n_chk++; if (m0_cmd_ready !== 1'b1) $display("FAIL wr_accept_d%0d got=%b exp=1", dly, m0_cmd_ready); else n_pass++;
        @(negedge clk);
        m0_cmd_valid = 0; m0_cmd_we_msk = 0; m0_din = 32'hFFFFFFFF;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (m0_valid) break;
            @(negedge clk);
        end
        n_chk++; if (m0_valid !== 1'b1) $display("FAIL wr_rsp_d%0d got=%b exp=1 (timeout)", dly, m0_valid); else n_pass++;
        n_chk++; if (s_din !== 32'h11223344) $display("FAIL wr_din_hold_d%0d got=%h exp=11223344", dly, s_din); else n_pass++;
        @(negedge clk);
        m1_cmd_valid = 1; m1_cmd_addr = 32'h20; #1;
        n_chk++; if (m1_cmd_ready !== 1'b1) $display("FAIL rd_m1_accept_d%0d got=%b exp=1", dly, m1_cmd_ready); else n_pass++;
        @(negedge clk);
        m1_cmd_valid = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (m1_valid) break;
            @(negedge clk);
        end
        n_chk++; if (m1_valid !== 1'b1) $display("FAIL rd_m1_rsp_d%0d got=%b exp=1 (timeout)", dly, m1_valid); else n_pass++;
        n_chk++; if (m1_dout !== 32'h00220044) $display("FAIL rd_m1_dout_d%0d got=%h exp=00220044", dly, m1_dout); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_backpressure();
        do_reset();
        slv_delay = 1;
        mem[6'h04] = 32'hDEADBEEF;
        mem[6'h0C] = 32'hCAFEF00D;
        mem[6'h05] = 32'h01020304;
        m0_ready = 0;
        @(negedge clk);
        m0_cmd_valid = 1; m0_cmd_addr = 32'h10; #1;
        n_chk++; if (m0_cmd_ready !== 1'b1) $display("FAIL bp_cmd1 got=%b exp=1", m0_cmd_ready); else n_pass++;
        @(negedge clk);
        m0_cmd_valid = 0; m1_cmd_valid = 1; m1_cmd_addr = 32'h30; #1;
        n_chk++; if (m1_cmd_ready !== 1'b1) $display("FAIL bp_cmd2 got=%b exp=1", m1_cmd_ready); else n_pass++;
        @(negedge clk);
        m1_cmd_valid = 0; m0_cmd_valid = 1; m0_cmd_addr = 32'h14; #1;
        n_chk++; if ({s_cmd_valid, m0_cmd_ready} !== 2'b00) $display("FAIL bp_cmd3_blocked got=%b exp=00", {s_cmd_valid, m0_cmd_ready}); else n_pass++;
        n_chk++; if ({m1_valid, m0_valid} !== 2'b01 || m0_dout !== 32'hDEADBEEF) $display("FAIL bp_head_m0 got=%b/%h exp=01/deadbeef", {m1_valid, m0_valid}, m0_dout); else n_pass++;
        @(negedge clk);
        m0_ready = 1; #1;
        n_chk++; if (m0_cmd_ready !== 1'b0) $display("FAIL bp_full_pop_blocks got=%b exp=0", m0_cmd_ready); else n_pass++;
        @(negedge clk); #1;
        n_chk++; if ({m1_valid, m0_valid} !== 2'b10 || m1_dout !== 32'hCAFEF00D) $display("FAIL bp_m1_rsp got=%b/%h exp=10/cafef00d", {m1_valid, m0_valid}, m1_dout); else n_pass++;
        n_chk++; if (m0_cmd_ready !== 1'b1) $display("FAIL bp_cmd3_accept got=%b exp=1", m0_cmd_ready); else n_pass++;
        @(negedge clk);
        m0_cmd_valid = 0; #1;
        n_chk++; if (m0_valid !== 1'b1 || m0_dout !== 32'h01020304) $display("FAIL bp_m0_rsp2 got=%b/%h exp=1/01020304", m0_valid, m0_dout); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_reset();
        slv_delay = 3;
        @(negedge clk);
        m0_cmd_valid = 1; m0_cmd_addr = 32'h10; #1;
        n_chk++; if (m0_cmd_ready !== 1'b1) $display("FAIL rstmid_accept got=%b exp=1", m0_cmd_ready); else n_pass++;
        @(negedge clk);
        m0_cmd_valid = 0;
        @(negedge clk);
        rst = 1; m0_cmd_valid = 1; m1_cmd_valid = 1; #1;
        n_chk++;
        if ({m0_valid, m1_valid, m0_cmd_ready, m1_cmd_ready, s_cmd_valid, s_ready} !== 6'b0)
            $display("FAIL rstmid_outputs got=%b exp=000000",
                     {m0_valid, m1_valid, m0_cmd_ready, m1_cmd_ready, s_cmd_valid, s_ready});
        else n_pass++;
        @(negedge clk);
        rst = 0; #1;
        n_chk++; if ({m1_cmd_ready, m0_cmd_ready} !== 2'b01) $display("FAIL rstmid_first_grant got=%b exp=01", {m1_cmd_ready, m0_cmd_ready}); else n_pass++;
        @(negedge clk);
        m0_cmd_valid = 0; m1_cmd_valid = 0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        test_reset();
        test_single_read();
        test_contention();
        test_grant_lock();
        test_write_read(1);
        test_write_read(3);
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
